// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with glitch filter, framing/parity check and FWFT FIFO; frame-abort timeout built only with PS2_RX_TIMEOUT_EN.
module ps2_rx #(
  parameter int CLK_FREQ   = 40_000_000,
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0] clk_s_q, data_s_q;
  logic clk_f_q, clk_f_d, data_f_q, data_f_d, clk_p_q;
  logic [FW-1:0] clk_c_q, clk_c_d, data_c_q, data_c_d;
  state_t st_q, st_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d;
  logic push, perr_d, ferr_d, perr_q, ferr_q, ovf_q;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fall, pop, full, wr_en, tmo;
  // a filtered line only follows the synchroniser after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    clk_c_d  = (clk_s_q[1] == clk_f_q || clk_c_q == FW'(FILTER_LEN - 1)) ? '0 : clk_c_q + 1'b1;
    clk_f_d  = (clk_s_q[1] != clk_f_q && clk_c_q == FW'(FILTER_LEN - 1)) ? clk_s_q[1] : clk_f_q;
    data_c_d = (data_s_q[1] == data_f_q || data_c_q == FW'(FILTER_LEN - 1)) ? '0 : data_c_q + 1'b1;
    data_f_d = (data_s_q[1] != data_f_q && data_c_q == FW'(FILTER_LEN - 1)) ? data_s_q[1] : data_f_q;
  end
  assign fall = clk_p_q & ~clk_f_q;
`ifdef PS2_RX_TIMEOUT_EN
  localparam longint LIMIT = longint'(TIMEOUT_US) * longint'(CLK_FREQ) / 64'd1_000_000;
  localparam int TW = $clog2(LIMIT + 1);
  logic [TW-1:0] tmo_q;
  assign tmo = tmo_q == TW'(LIMIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_q <= '0;
    else     tmo_q <= (st_q == IDLE || fall || tmo) ? '0 : tmo_q + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    st_d   = st_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    par_d  = par_q;
    push   = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    if (tmo) begin
      st_d   = IDLE;
      ferr_d = 1'b1;
    end else if (fall) begin
      case (st_q)
        IDLE: begin
          st_d  = data_f_q ? IDLE : DATA;
          bit_d = '0;
        end
        DATA: begin
          sh_d  = {data_f_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          st_d  = (bit_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = data_f_q;
          st_d  = STOP;
        end
        default: begin
          st_d   = IDLE;
          push   = data_f_q & ^{sh_q, par_q};
          perr_d = data_f_q & ~^{sh_q, par_q};
          ferr_d = ~data_f_q;
        end
      endcase
    end
  end
  assign rx_valid = cnt_q != '0;
  assign rx_data  = rx_valid ? mem_q[rd_q] : '0;
  assign pop      = rx_valid & rx_ready;
  assign full     = cnt_q == CW'(FIFO_DEPTH);
  assign wr_en    = push & (~full | pop);
  assign cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
  assign busy       = st_q != IDLE;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_s_q  <= 2'b11;
      data_s_q <= 2'b11;
      clk_f_q  <= 1'b1;
      data_f_q <= 1'b1;
      clk_p_q  <= 1'b1;
      clk_c_q  <= '0;
      data_c_q <= '0;
      st_q     <= IDLE;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      clk_s_q  <= {clk_s_q[0], ps2_clk};
      data_s_q <= {data_s_q[0], ps2_data};
      clk_f_q  <= clk_f_d;
      data_f_q <= data_f_d;
      clk_p_q  <= clk_f_q;
      clk_c_q  <= clk_c_d;
      data_c_q <= data_c_d;
      st_q     <= st_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovf_q    <= push & full & ~pop;
      wr_q     <= wr_en ? wr_q + 1'b1 : wr_q;
      rd_q     <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q    <= cnt_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= sh_q;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed bench for ps2_rx; PS/2 bit period shortened to 100 clk to keep runtime small.
module tb_ps2_rx;
  localparam int HALF   = 50;
  localparam int TO_CYC = 10000;
  logic clk, rst, ps2_clk, ps2_data, rx_ready;
  logic [7:0] rx_data;
  logic rx_valid, parity_err, frame_err, overflow, busy;
  int checks, errors, perr_n, ferr_n, ovf_n, busy_seen;
  ps2_rx dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (parity_err) perr_n++;
    if (frame_err) ferr_n++;
    if (overflow) ovf_n++;
    if (busy) busy_seen++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] frm(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    return {~bad_stop, ~^b ^ bad_par, b, 1'b0};
  endfunction
  // mode 1: exact latency check on the stop bit; mode 2: single-cycle pop in the push cycle
  task automatic send(input logic [10:0] f, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (10) @(negedge clk);
        chk("latency_pre", rx_valid, 0);
        @(negedge clk);
        chk("latency_valid", rx_valid, 1);
        chk("latency_data", rx_data, 8'h1C);
        repeat (HALF - 11) @(negedge clk);
      end else if (i == 10 && mode == 2) begin
        repeat (10) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (HALF - 11) @(negedge clk);
      end else repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask
  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  initial begin
    checks = 0; errors = 0; perr_n = 0; ferr_n = 0; ovf_n = 0; busy_seen = 0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {parity_err, frame_err, overflow}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(frm(8'h1C, 0, 0), 11, 1);
    chk("good_pulses", perr_n + ferr_n + ovf_n, 0);
    pop_one();
    chk("good_popped", rx_valid, 0);
    send(frm(8'hF0, 1, 0), 11, 0);
    chk("par_err_pulse", perr_n, 1);
    chk("par_err_novalid", rx_valid, 0);
    send(frm(8'hF0, 0, 0), 11, 0);
    chk("par_ok_valid", rx_valid, 1);
    chk("par_ok_data", rx_data, 8'hF0);
    pop_one();
    send(frm(8'h55, 1, 1), 11, 0);
    chk("stop_err_pulse", ferr_n, 1);
    chk("stop_err_noperr", perr_n, 1);
    chk("stop_err_novalid", rx_valid, 0);
    busy_seen = 0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy", busy_seen, 0);
    for (int i = 1; i <= 9; i++) begin
      send(frm(8'(i), 0, 0), 11, 0);
      if (i == 8) chk("fill_no_ovf", ovf_n, 0);
    end
    chk("ovf_pulse", ovf_n, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", rx_data, i);
      pop_one();
    end
    chk("drain_empty", rx_valid, 0);
    for (int i = 0; i < 8; i++) send(frm(8'(8'h10 + i), 0, 0), 11, 0);
    send(frm(8'h18, 0, 0), 11, 2);
    chk("popush_no_ovf", ovf_n, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("popush_order", rx_data, 8'h10 + i);
      pop_one();
    end
    chk("popush_empty", rx_valid, 0);
    send(frm(8'h11, 0, 0), 11, 0);
    send(frm(8'h22, 0, 0), 11, 0);
    send(frm(8'h44, 0, 0), 6, 0);
    chk("mid_busy", busy, 1);
    chk("mid_head", rx_data, 8'h11);
    rst = 1'b1;
    #1;
    chk("arst_valid", rx_valid, 0);
    chk("arst_data", rx_data, 0);
    chk("arst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("arst_no_pulse", perr_n * 100 + ferr_n * 10 + ovf_n, 111);
    send(frm(8'h29, 0, 0), 11, 0);
    chk("after_rst_data", rx_data, 8'h29);
    pop_one();
    chk("after_rst_empty", rx_valid, 0);
    send(frm(8'h33, 0, 0), 5, 0);
    chk("tmo_busy", busy, 1);
    repeat (7900) @(negedge clk);
    chk("tmo_not_yet", ferr_n, 1);
    repeat (TO_CYC - 7900) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    chk("tmo_pulse", ferr_n, 2);
    chk("tmo_idle", busy, 0);
    send(frm(8'h5A, 0, 0), 11, 0);
    chk("tmo_next_data", rx_data, 8'h5A);
`else
    chk("notmo_pulse", ferr_n, 1);
    chk("notmo_busy", busy, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Host-side PS/2 receiver for the Basys3 USB-HID bridge; consumes the device-driven PS2Clk/PS2Data pins routed through top.
- Deserialises 11-bit device-to-host frames into scan-code bytes and checks framing and parity.
- Buffers bytes in a small FIFO and presents them on a valid/ready interface for a future SoC peripheral wrapper.

Parameters:
- CLK_FREQ, 40_000_000, core clock frequency in Hz.
- FILTER_LEN, 8, consecutive identical samples required before a filtered PS/2 line changes.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, ≥2.
- TIMEOUT_US, 200, frame-abort timeout in µs; used only when PS2_RX_TIMEOUT_EN is defined.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous, idle high.
- ps2_data  input  1  raw PS/2 data pin, asynchronous, idle high.
- rx_data  output  8  byte at FIFO head.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts rx_data.
- parity_err  output  1  one-cycle pulse when a frame is discarded for bad parity.
- frame_err  output  1  one-cycle pulse when a frame is discarded for bad stop bit or timeout.
- overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- busy  output  1  high while FSM is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - Synchronisers and filtered lines set to 1.
  - FSM to IDLE, FIFO empty, all counters 0.
  - rx_valid, rx_data, parity_err, frame_err, overflow, busy all 0.
- Input conditioning:
  - Each pin passes through a 2-flop synchroniser.
  - The filtered line takes the synchronised value after FILTER_LEN consecutive equal samples.
  - Fall event = filtered clock 1→0; data is sampled from filtered ps2_data in that same cycle.
- FSM (advances only on fall events):
  - IDLE: data=0 → DATA, bit count 0. data=1 → ignored, stay IDLE.
  - DATA: shift in LSB first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP, frame is discarded in every non-accepted case, always → IDLE:
    - stop=1 and odd parity over 8 data bits + parity bit → byte accepted.
    - stop=1 and parity wrong → parity_err pulse.
    - stop=0 → frame_err pulse; takes precedence over a parity error.
- Latency: on an accepted byte, rx_valid/rx_data reflect it in the cycle after the stop-bit fall event, when the FIFO was previously empty.
- FIFO:
  - First-word-fall-through; rx_data = head entry, 0 when empty.
  - Pop when rx_valid && rx_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle (simultaneous pop+push keeps the count).
  - Full with no pop → byte dropped, overflow pulse, contents unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH+1).
  - rx_ready while empty has no effect.
- Pulse timing: error and overflow pulses are exactly 1 clk, aligned to the push cycle.
- Reset mid-frame: partial frame discarded, FIFO cleared, no error pulse.
- The block never drives the PS/2 lines (no host-to-device inhibit).

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is not IDLE and clears on each fall event.
  - At TIMEOUT_US*CLK_FREQ/1_000_000 cycles (8000 at defaults) → FSM to IDLE, frame_err pulse, partial byte discarded.
  - Counter width is $clog2(limit+1).
- Not defined:
  - No counter logic.
  - A partial frame persists until further fall events arrive, so a lost clock edge misaligns subsequent frames.

Test Plan:
- Good frame: device sends 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz (3200-cycle period) → rx_valid=1, rx_data=0x1C one cycle after stop fall; no error pulses; pop with rx_ready → rx_valid=0.
- Parity error: 0xF0 sent with parity 0 (correct is 1) → one parity_err pulse, rx_valid stays 0; next frame 0xF0 with parity 1 → rx_data=0xF0.
- Stop error and glitch rejection: frame with stop=0 → frame_err pulse only. A 3-cycle low glitch on ps2_clk (shorter than FILTER_LEN) → no fall event, busy stays 0.
- FIFO full, overflow, and pop+push: rx_ready=0, send 9 frames 0x01..0x09 → FIFO holds 0x01..0x08, one overflow pulse on 0x09. Drain gives 0x01..0x08 in order. Full FIFO with rx_ready=1 during a push → count unchanged, new byte appended, no overflow.
- Timeout (PS2_RX_TIMEOUT_EN): stop the clock after 4 data bits for 250 µs → frame_err pulse at 8000 cycles after the last fall, busy→0. A following full frame 0x5A is received correctly. Without the macro: no pulse, busy stays 1.
- Async reset mid-frame: assert rst after bit 5 with 2 bytes queued → all outputs 0 immediately, FIFO empty. Next full frame 0x29 → rx_data=0x29.
